// File: rtl/data_arb_pkg.sv
// data_arb_pkg: shared types and constants for the MMIO data-port arbiter family.
package data_arb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        RESP,
        ERR
    } arb_state_e;

    localparam logic [31:0] ERR_RDATA   = 32'hDEAD_BEEF;
    localparam int          MAX_MASTERS = 4;

endpackage

// File: rtl/rr_picker.sv
// rr_picker: round-robin choice of the first requester at or after the pointer.
module rr_picker #(
    parameter int  N = 2,
    localparam int W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0] i_req,
    input  logic [W-1:0] i_ptr,
    output logic [W-1:0] o_idx,
    output logic         o_any
);

    logic [W-1:0] w_cand;

    // Scan from the farthest offset down so the nearest requester wins last.
    always_comb begin
        o_idx  = '0;
        w_cand = '0;
        for (int k = N - 1; k >= 0; k--) begin
            w_cand = W'((int'(i_ptr) + k) % N);
            if (i_req[w_cand]) o_idx = w_cand;
        end
        o_any = |i_req;
    end

endmodule

// File: rtl/data_bus_arbiter.sv
// data_bus_arbiter: round-robin sharing of the single MMIO data port between
// NUM_MASTERS requesters, one transaction in flight, with a per-phase watchdog.
module data_bus_arbiter
    import data_arb_pkg::*;
#(
    parameter int NUM_MASTERS    = 2,
    parameter int TIMEOUT_CYCLES = 255,
    localparam int W = $clog2(NUM_MASTERS)
) (
    input  logic                        clk_i,
    input  logic                        rst_n,
    input  logic [NUM_MASTERS-1:0]      m_req_i,
    input  logic [NUM_MASTERS-1:0][31:0] m_addr_i,
    input  logic [NUM_MASTERS-1:0][31:0] m_wdata_i,
    input  logic [NUM_MASTERS-1:0]      m_we_i,
    input  logic [NUM_MASTERS-1:0][3:0] m_be_i,
    output logic [NUM_MASTERS-1:0]      m_gnt_o,
    output logic [NUM_MASTERS-1:0]      m_rvalid_o,
    output logic [31:0]                 m_rdata_o,
    output logic                        m_err_o,
    output logic                        s_req_o,
    output logic [31:0]                 s_addr_o,
    output logic [31:0]                 s_wdata_o,
    output logic                        s_we_o,
    output logic [3:0]                  s_be_o,
    input  logic                        s_gnt_i,
    input  logic                        s_rvalid_i,
    input  logic [31:0]                 s_rdata_i
);

    localparam int WDW = (TIMEOUT_CYCLES > 255) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
    localparam logic [WDW-1:0] WD_LAST = WDW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

    arb_state_e     r_state;
    logic [W-1:0]   r_winner;
    logic [W-1:0]   r_rr;
    logic [WDW-1:0] r_wd_cnt;

    logic [W-1:0]           w_pick;
    logic [W-1:0]           w_rr_next;
    logic                   w_any;
    logic                   w_wd_hit;
    logic                   w_in_req;
    logic                   w_gnt;
    logic                   w_rsp_ok;
    logic                   w_rsp_err;
    logic [NUM_MASTERS-1:0] w_onehot;

    rr_picker #(.N(NUM_MASTERS)) u_pick (
        .i_req (m_req_i),
        .i_ptr (r_rr),
        .o_idx (w_pick),
        .o_any (w_any)
    );

    // A zero limit leaves the watchdog permanently disarmed.
    always_comb begin
        w_wd_hit   = (TIMEOUT_CYCLES != 0) && (r_wd_cnt == WD_LAST);
        w_in_req   = r_state == REQ;
        w_onehot   = NUM_MASTERS'(1) << r_winner;
        w_rr_next  = (r_winner == W'(NUM_MASTERS - 1)) ? '0 : r_winner + W'(1);
        w_gnt      = w_in_req && (s_gnt_i || w_wd_hit);
        w_rsp_ok   = (r_state == RESP) && s_rvalid_i;
        w_rsp_err  = ((r_state == RESP) && !s_rvalid_i && w_wd_hit) || (r_state == ERR);
        s_req_o    = w_in_req;
        s_addr_o   = w_in_req ? m_addr_i[r_winner] : '0;
        s_wdata_o  = w_in_req ? m_wdata_i[r_winner] : '0;
        s_we_o     = w_in_req && m_we_i[r_winner];
        s_be_o     = w_in_req ? m_be_i[r_winner] : '0;
        m_gnt_o    = w_gnt ? w_onehot : '0;
        m_rvalid_o = (w_rsp_ok || w_rsp_err) ? w_onehot : '0;
        m_err_o    = w_rsp_err;
        m_rdata_o  = w_rsp_err ? ERR_RDATA : (w_rsp_ok ? s_rdata_i : '0);
    end

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= IDLE;
            r_winner <= '0;
            r_rr     <= '0;
            r_wd_cnt <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_any) begin
                        r_winner <= w_pick;
                        r_wd_cnt <= '0;
                        r_state  <= REQ;
                    end
                end
                REQ: begin
                    if (s_gnt_i) begin
                        r_wd_cnt <= '0;
                        r_state  <= RESP;
                    end else if (w_wd_hit) begin
                        r_wd_cnt <= '0;
                        r_state  <= ERR;
                    end else begin
                        r_wd_cnt <= r_wd_cnt + WDW'(1);
                    end
                end
                RESP: begin
                    if (s_rvalid_i || w_wd_hit) begin
                        r_rr    <= w_rr_next;
                        r_state <= IDLE;
                    end else begin
                        r_wd_cnt <= r_wd_cnt + WDW'(1);
                    end
                end
                default: begin
                    r_rr    <= w_rr_next;
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/data_bus_arbiter.md
# data_bus_arbiter

Two-to-four-master arbiter that shares the single MMIO data port (ROM/RAM/GPIO/UART address space) between requesters, e.g. the core data port and a DMA or debug master. Requests are arbitrated round-robin, and one transaction is in flight at a time. Each response is routed back to its issuing master. A cycle-count watchdog converts a stalled grant or response into an error response, so a dead peripheral cannot hang the bus.

## Interface
- NUM_MASTERS, 2, number of requesters (2..4)
- TIMEOUT_CYCLES, 255, watchdog limit per phase; 0 disables the watchdog
- clk_i  in  1  system clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- m_req_i  in  NUM_MASTERS  per-master request; held until matching m_gnt_o
- m_addr_i  in  NUM_MASTERS x 32  per-master address (packed [NUM_MASTERS-1:0][31:0])
- m_wdata_i  in  NUM_MASTERS x 32  per-master write data
- m_we_i  in  NUM_MASTERS  per-master write enable
- m_be_i  in  NUM_MASTERS x 4  per-master byte enables
- m_gnt_o  out  NUM_MASTERS  one-hot grant
- m_rvalid_o  out  NUM_MASTERS  one-hot response valid
- m_rdata_o  out  32  shared read data, valid with any m_rvalid_o bit
- m_err_o  out  1  response is a watchdog error, qualified by m_rvalid_o
- s_req_o, s_addr_o[31:0], s_wdata_o[31:0], s_we_o, s_be_o[3:0]  out  request fields toward the MMIO controller
- s_gnt_i  in  1  controller grant
- s_rvalid_i  in  1  controller response valid
- s_rdata_i  in  32  controller read data

## Operation
- States: IDLE, REQ, RESP, ERR. Registers: state_q, winner_q (clog2 width), rr_q, wd_cnt_q (8+ bits, sized to TIMEOUT_CYCLES).
- IDLE, any m_req_i set:
  - Winner is the first requesting index at or after rr_q, wrapping modulo NUM_MASTERS.
  - Latch winner_q and clear wd_cnt_q.
  - Next state is REQ.
  - No outputs are asserted in IDLE.
- REQ:
  - s_req_o=1; s_addr_o, s_wdata_o, s_we_o, s_be_o are driven combinationally from master winner_q.
  - On s_gnt_i: m_gnt_o[winner_q]=1 in the same cycle, clear wd_cnt_q, next state RESP.
  - Otherwise wd_cnt_q increments. When wd_cnt_q==TIMEOUT_CYCLES-1 without s_gnt_i: m_gnt_o[winner_q]=1, s_req_o stays 1 for this last cycle, next state ERR.
- RESP:
  - s_req_o=0.
  - On s_rvalid_i: m_rvalid_o[winner_q]=1, m_rdata_o=s_rdata_i, m_err_o=0, next state IDLE.
  - When wd_cnt_q reaches TIMEOUT_CYCLES-1 without s_rvalid_i: m_rvalid_o[winner_q]=1, m_err_o=1, m_rdata_o=ERR_RDATA, next state IDLE.
- ERR: m_rvalid_o[winner_q]=1, m_err_o=1, m_rdata_o=ERR_RDATA; next state IDLE.
- rr_q updates to (winner_q+1) mod NUM_MASTERS on every transition into IDLE. Its reset value is 0.
- s_rvalid_i and s_gnt_i are ignored in IDLE and ERR. s_rvalid_i is ignored in REQ; the controller responds at least one cycle after its grant.
- m_req_i is not monitored after winner selection; masters hold requests per protocol. A withdrawn request still completes.
- When no m_rvalid_o is active, m_rdata_o=0 and m_err_o=0.
- Writes complete through the same RESP phase; the rvalid response is required and its rdata is don't-care.

## Timing
- Reset values: every output is 0, state_q=IDLE, rr_q=0, winner_q=0, wd_cnt_q=0.
- Asserting rst_n mid-transaction aborts immediately, with no response to the master. A late slave response is dropped in IDLE.
- Minimum transaction length is 3 cycles (IDLE, REQ with same-cycle gnt, RESP with rvalid on the next cycle). Back-to-back throughput is 1 transaction per 3 cycles.
- Grant and response to the master are combinational from s_gnt_i and s_rvalid_i. There is no added latency beyond the state steps.
- Simultaneous requests: the lowest index at or above rr_q wins. Losers keep requesting and are served in rotation, with no starvation beyond NUM_MASTERS-1 transactions.
- Watchdog: the timeout response appears exactly TIMEOUT_CYCLES cycles after REQ or RESP entry. With TIMEOUT_CYCLES=0 the watchdog never fires.

## Structure
- Package data_arb_pkg:
  - arb_state_e enum (IDLE, REQ, RESP, ERR)
  - ERR_RDATA = 32'hDEAD_BEEF
  - MAX_MASTERS = 4
- Sub-module rr_picker: a combinational function of (req vector, rr pointer) that returns a winner index and an any flag. It is reused by later multi-master blocks.

## Test plan
- Single master: m_req_i=01, addr 0x0040_0010, s_gnt_i same cycle, s_rvalid_i next cycle with 0x1234_5678. Required: m_gnt_o=01 in REQ, m_rvalid_o=01 with rdata 0x1234_5678, m_err_o=0.
- Contention: both masters request continuously for 4 transactions from reset. Required grant order is 0,1,0,1, each transaction 3 cycles.
- Grant stall: TIMEOUT_CYCLES=8, s_gnt_i never asserted. Required: m_gnt_o[0] at REQ cycle 8, then m_rvalid_o[0], m_err_o=1, rdata 0xDEAD_BEEF in the next cycle.
- Response stall: gnt given, no s_rvalid_i. Required: error response exactly 8 cycles after RESP entry, then return to IDLE and serve the pending master 1.
- Reset mid-RESP: drop rst_n during RESP, then release and send a late s_rvalid_i. Required: all outputs stay 0 and rr_q=0.
- Write to GPIO 0x8000_0004 from master 1, be=0011. Required: s_addr_o, s_wdata_o, s_be_o and s_we_o mirror master 1's fields exactly during REQ.
